// File: rtl/can_tx_serializer.sv
// can_tx_serializer: CAN 2.0A standard data frame transmitter.
// It latches ID, DLC and payload on an accepted start pulse. It then drives SOF,
// arbitration, control, data, CRC-15, delimiters, ACK slot, EOF and IFS on can_tx,
// holding each bit for BIT_CYCLES clocks and inserting bit stuffing from SOF through CRC.
// Optional feature macro: CAN_TX_ACK_CHECK_EN samples can_rx in the ACK slot and
// flags a missing acknowledge on ack_err.
module can_tx_serializer #(
   parameter int BIT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_start,
   input  logic [10:0] tx_id,
   input  logic [3:0]  tx_len,
   input  logic [63:0] tx_data,
   input  logic        can_rx,
   output logic        can_tx,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        ack_err
);

   localparam int            PW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(BIT_CYCLES - 1);
   localparam logic [14:0]   CRC_POLY   = 15'h4599;

   typedef enum logic [2:0] {S_IDLE, S_ARB, S_DATA, S_CRC, S_TAIL} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [5:0]    cnt_q, cnt_d;       // bit index within the current field
   logic [10:0]   id_q, id_d;
   logic [3:0]    dlc_q, dlc_d;
   logic [63:0]   data_q, data_d;
   logic [14:0]   crc_q, crc_d;
   logic [2:0]    run_q, run_d;       // length of the current run of equal wire bits
   logic          last_q, last_d;     // last bit put on the wire (stuff bits included)
   logic          tx_q, tx_d;
   logic          done_q, done_d;

   // Field bookkeeping derived from the latched frame
   logic [3:0]  nbytes;
   logic [5:0]  data_last;
   logic [18:0] arb_bits;
   logic        stuff_region;

   assign nbytes       = dlc_q[3] ? 4'd8 : dlc_q;
   assign data_last    = 6'({nbytes, 3'b000} - 7'd1);
   assign arb_bits     = {1'b0, id_q, 3'b000, dlc_q};   // SOF, ID, RTR, IDE, r0, DLC
   assign stuff_region = (state_q == S_ARB) || (state_q == S_DATA) || (state_q == S_CRC);

   // One CRC-15 step over a single unstuffed bit
   function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
      logic nxt;
      nxt      = b ^ crc[14];
      crc_step = {crc[13:0], 1'b0} ^ (nxt ? CRC_POLY : 15'h0000);
   endfunction

   // Position of the next unstuffed bit, and whether the frame ends after the current bit
   state_t     pos_state;
   logic [5:0] pos_cnt;
   logic       pos_end;

   always_comb begin
      pos_state = state_q;
      pos_cnt   = cnt_q + 6'd1;
      pos_end   = 1'b0;
      case (state_q)
         S_ARB: begin
            if (cnt_q == 6'd18) begin
               pos_state = (nbytes != 4'd0) ? S_DATA : S_CRC;
               pos_cnt   = 6'd0;
            end
         end
         S_DATA: begin
            if (cnt_q == data_last) begin
               pos_state = S_CRC;
               pos_cnt   = 6'd0;
            end
         end
         S_CRC: begin
            if (cnt_q == 6'd14) begin
               pos_state = S_TAIL;
               pos_cnt   = 6'd0;
            end
         end
         S_TAIL: begin
            if (cnt_q == 6'd12) begin
               pos_end = 1'b1;
            end
         end
         default: begin
            pos_end = 1'b0;
         end
      endcase
   end

   // Value of the next unstuffed bit; TAIL and IDLE are always recessive
   logic [4:0] arb_idx;
   logic [3:0] crc_idx;
   logic [5:0] data_idx;
   logic       pos_bit;

   assign arb_idx  = 5'(5'd18 - pos_cnt[4:0]);
   assign crc_idx  = 4'(4'd14 - pos_cnt[3:0]);
   assign data_idx = {pos_cnt[5:3], ~pos_cnt[2:0]};      // byte-ascending, MSB first in byte

   always_comb begin
      pos_bit = 1'b1;
      case (pos_state)
         S_ARB:   pos_bit = arb_bits[arb_idx];
         S_DATA:  pos_bit = data_q[data_idx];
         S_CRC:   pos_bit = crc_q[crc_idx];
         default: pos_bit = 1'b1;
      endcase
   end

   // Next-state logic: accept start, run the prescaler, emit stuff or field bits at bit boundaries
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      dlc_d   = dlc_q;
      data_d  = data_q;
      crc_d   = crc_q;
      run_d   = run_q;
      last_d  = last_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      if (state_q == S_IDLE) begin
         if (tx_start) begin
            // SOF goes out on the accepting edge; dominant 0 leaves the CRC at 0
            state_d = S_ARB;
            presc_d = '0;
            cnt_d   = 6'd0;
            id_d    = tx_id;
            dlc_d   = tx_len;
            data_d  = tx_data;
            crc_d   = 15'h0000;
            run_d   = 3'd1;
            last_d  = 1'b0;
            tx_d    = 1'b0;
         end
      end else if (presc_q != PRESC_LAST) begin
         presc_d = presc_q + PW'(1);
      end else begin
         presc_d = '0;
         if (stuff_region && (run_q == 3'd5)) begin
            // Stuff bit: complement, starts a new run, field position unchanged
            tx_d   = ~last_q;
            last_d = ~last_q;
            run_d  = 3'd1;
         end else if (pos_end) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
            tx_d    = 1'b1;
            done_d  = 1'b1;
         end else begin
            state_d = pos_state;
            cnt_d   = pos_cnt;
            tx_d    = pos_bit;
            last_d  = pos_bit;
            run_d   = (pos_bit == last_q) ? run_q + 3'd1 : 3'd1;
            if ((pos_state == S_ARB) || (pos_state == S_DATA)) begin
               crc_d = crc_step(crc_q, pos_bit);
            end
         end
      end
   end

   // Frame state registers; reset aborts any frame in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         cnt_q   <= 6'd0;
         id_q    <= 11'd0;
         dlc_q   <= 4'd0;
         data_q  <= 64'd0;
         crc_q   <= 15'h0000;
         run_q   <= 3'd0;
         last_q  <= 1'b1;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         dlc_q   <= dlc_d;
         data_q  <= data_d;
         crc_q   <= crc_d;
         run_q   <= run_d;
         last_q  <= last_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   assign can_tx  = tx_q;
   assign tx_busy = (state_q != S_IDLE);
   assign tx_done = done_q;

`ifdef CAN_TX_ACK_CHECK_EN
   localparam logic [PW-1:0] ACK_SAMPLE = PW'(BIT_CYCLES / 2);

   logic ack_rx_q, ack_rx_d;
   logic ack_err_q, ack_err_d;

   // Sample the bus mid ACK slot; report a recessive sample together with tx_done
   always_comb begin
      ack_rx_d  = ack_rx_q;
      ack_err_d = 1'b0;
      if ((state_q == S_IDLE) && tx_start) begin
         ack_rx_d = 1'b1;
      end
      if ((state_q == S_TAIL) && (cnt_q == 6'd1) && (presc_q == ACK_SAMPLE)) begin
         ack_rx_d = can_rx;
      end
      if (done_d) begin
         ack_err_d = ack_rx_q;
      end
   end

   // ACK check registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_rx_q  <= 1'b1;
         ack_err_q <= 1'b0;
      end else begin
         ack_rx_q  <= ack_rx_d;
         ack_err_q <= ack_err_d;
      end
   end

   assign ack_err = ack_err_q;
`else
   logic unused_can_rx;
   assign unused_can_rx = can_rx;
   assign ack_err       = 1'b0;
`endif

endmodule

// File: tb/tb_can_tx_serializer.sv
// Directed testbench for can_tx_serializer (BIT_CYCLES = 16).
// Samples can_tx mid-bit, compares against hand-built or reference-built bit streams,
// and checks timing, stuffing, CRC, DLC clamp, start handling, ACK flag and abort.
module tb_can_tx_serializer;

   localparam int BC = 16;
`ifdef CAN_TX_ACK_CHECK_EN
   localparam logic ACK_EN = 1'b1;
`else
   localparam logic ACK_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        tx_start;
   logic [10:0] tx_id;
   logic [3:0]  tx_len;
   logic [63:0] tx_data;
   logic        can_rx;
   logic        can_tx;
   logic        tx_busy;
   logic        tx_done;
   logic        ack_err;

   can_tx_serializer #(.BIT_CYCLES(BC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_start (tx_start),
      .tx_id    (tx_id),
      .tx_len   (tx_len),
      .tx_data  (tx_data),
      .can_rx   (can_rx),
      .can_tx   (can_tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .ack_err  (ack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        cap_w [0:255];
   int          cap_n;
   logic        exp_w [0:255];
   int          exp_n;
   logic        ds_w [0:255];
   int          ds_n;
   int          max_run;
   logic [14:0] exp_crc;
   int          done_k;
   logic        done_ack;
   logic        done_busy;
   int          busy_drop;
   int          ref_ds_n;
   int          bad;
   logic [31:0] val;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   // Reference frame builder: unstuffed bits, CRC-15, stuffing, then 13 recessive tail bits
   task automatic build_model(input logic [10:0] id, input logic [3:0] len, input logic [63:0] data);
      logic        raw [0:159];
      int          nraw;
      int          nb;
      int          run;
      logic        last;
      logic        nxt;
      logic [14:0] crc;
      nb      = (len > 4'd8) ? 8 : int'(len);
      raw[0]  = 1'b0;
      nraw    = 1;
      for (int i = 10; i >= 0; i--) begin raw[nraw] = id[i]; nraw++; end
      for (int i = 0; i < 3; i++) begin raw[nraw] = 1'b0; nraw++; end
      for (int i = 3; i >= 0; i--) begin raw[nraw] = len[i]; nraw++; end
      for (int b = 0; b < nb; b++) begin
         for (int i = 7; i >= 0; i--) begin raw[nraw] = data[8*b+i]; nraw++; end
      end
      crc = 15'h0;
      for (int i = 0; i < nraw; i++) begin
         nxt = raw[i] ^ crc[14];
         crc = {crc[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0);
      end
      exp_crc = crc;
      for (int i = 14; i >= 0; i--) begin raw[nraw] = crc[i]; nraw++; end
      exp_n = 0;
      run   = 0;
      last  = 1'b0;
      for (int i = 0; i < nraw; i++) begin
         exp_w[exp_n] = raw[i];
         exp_n++;
         if (run > 0 && raw[i] == last) run++; else run = 1;
         last = raw[i];
         if (run == 5) begin
            exp_w[exp_n] = ~last;
            exp_n++;
            last = ~last;
            run  = 1;
         end
      end
      for (int i = 0; i < 13; i++) begin exp_w[exp_n] = 1'b1; exp_n++; end
   endtask

   // Pulse tx_start with a frame, then scramble the inputs to prove they were latched
   task automatic start_frame(input logic [10:0] id, input logic [3:0] len, input logic [63:0] data);
      tx_id    = id;
      tx_len   = len;
      tx_data  = data;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      tx_id    = ~id;
      tx_len   = ~len;
      tx_data  = ~data;
   endtask

   // Record mid-bit samples until tx_done; k=0 is just after the SOF edge
   task automatic capture(input int inject_at, input int ack_lo, input int ack_hi);
      cap_n     = 0;
      done_k    = -1;
      done_ack  = 1'bx;
      done_busy = 1'bx;
      busy_drop = 0;
      for (int k = 0; k < 4000; k++) begin
         if (tx_done === 1'b1) begin
            done_k    = k;
            done_ack  = ack_err;
            done_busy = tx_busy;
            break;
         end
         if (tx_busy !== 1'b1) busy_drop++;
         if ((k % BC) == BC/2 && cap_n < 256) begin
            cap_w[cap_n] = can_tx;
            cap_n++;
         end
         if (k == inject_at) begin
            tx_start = 1'b1;
            tx_id    = 11'h7FF;
            tx_len   = 4'd8;
            tx_data  = '1;
         end else begin
            tx_start = 1'b0;
         end
         can_rx = (k >= ack_lo && k < ack_hi) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
      end
      can_rx = 1'b1;
   endtask

   task automatic stream_check(input string tag);
      check({tag, "_nbits"}, cap_n, exp_n);
      bad = 0;
      for (int i = 0; i < cap_n && i < exp_n; i++) begin
         if (cap_w[i] !== exp_w[i]) bad++;
      end
      check({tag, "_bits_bad"}, bad, 0);
      check({tag, "_busy_drop"}, busy_drop, 0);
   endtask

   // Remove stuff bits from the stuffed region and measure the longest raw run there
   task automatic destuff();
      int   run;
      int   rrun;
      logic last;
      logic rlast;
      int   lim;
      lim     = (cap_n > 13) ? cap_n - 13 : 0;
      ds_n    = 0;
      run     = 0;
      rrun    = 0;
      max_run = 0;
      last    = 1'b0;
      rlast   = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (rrun > 0 && cap_w[i] === rlast) rrun++; else rrun = 1;
         rlast = cap_w[i];
         if (rrun > max_run) max_run = rrun;
         if (run == 5) begin
            run  = 1;
            last = cap_w[i];
         end else begin
            ds_w[ds_n] = cap_w[i];
            ds_n++;
            if (run > 0 && cap_w[i] === last) run++; else run = 1;
            last = cap_w[i];
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_start = 1'b0;
      tx_id    = '0;
      tx_len   = '0;
      tx_data  = '0;
      can_rx   = 1'b1;
      ref_ds_n = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_can_tx", can_tx, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
      check("rst_ack_err", ack_err, 0);
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (can_tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || ack_err !== 1'b0) bad++;
      end
      check("idle_after_reset", bad, 0);
      $display("txn reset: idle checks done");

      // All-zero frame: 34 zeros with a stuffed 1 after every fifth up to 30, then 13 ones
      exp_n = 0;
      for (int i = 1; i <= 34; i++) begin
         exp_w[exp_n] = 1'b0; exp_n++;
         if ((i % 5) == 0 && i <= 30) begin exp_w[exp_n] = 1'b1; exp_n++; end
      end
      for (int i = 0; i < 13; i++) begin exp_w[exp_n] = 1'b1; exp_n++; end
      start_frame(11'h000, 4'd0, 64'd0);
      check("zero_sof", can_tx, 0);
      check("zero_busy_start", tx_busy, 1);
      capture(-1, -1, -1);
      check("zero_len53", cap_n, 53);
      stream_check("zero");
      check("zero_done_at_848", done_k, 848);
      check("zero_busy_at_done", done_busy, 0);
      check("zero_ack_err", done_ack, ACK_EN);
      $display("txn zero frame: bits=%0d done_k=%0d", cap_n, done_k);

      // Full payload frame against the reference builder
      repeat (5) @(posedge clk);
      #1;
      build_model(11'h123, 4'd8, 64'h0011223344556677);
      start_frame(11'h123, 4'd8, 64'h0011223344556677);
      check("full_sof", can_tx, 0);
      capture(-1, -1, -1);
      stream_check("full");
      check("full_done_time", done_k, exp_n * BC);
      destuff();
      check("full_max_run_le5", (max_run <= 5), 1);
      check("full_unstuffed_len", ds_n, 98);
      val = 0;
      for (int i = 0; i < 15; i++) val = {val[30:0], ds_w[ds_n-15+i]};
      check("full_crc", val, {17'd0, exp_crc});
      check("full_ack_err_rx1", done_ack, ACK_EN);
      ref_ds_n = ds_n;
      $display("txn full: bits=%0d crc=%04h done_k=%0d", cap_n, exp_crc, done_k);

      // DLC clamp: DLC 12 sends 64 data bits and 1100 in the DLC field
      repeat (3) @(posedge clk);
      #1;
      build_model(11'h123, 4'd12, 64'h0011223344556677);
      start_frame(11'h123, 4'd12, 64'h0011223344556677);
      capture(-1, -1, -1);
      stream_check("dlc12");
      destuff();
      val = {28'd0, ds_w[15], ds_w[16], ds_w[17], ds_w[18]};
      check("dlc12_field", val, 4'b1100);
      check("dlc12_unstuffed_len", ds_n, ref_ds_n);
      check("dlc12_data_bits", ds_n - 34, 64);
      $display("txn dlc12: bits=%0d unstuffed=%0d", cap_n, ds_n);

      // Start while busy is ignored; inputs changed mid-frame do not leak in
      repeat (3) @(posedge clk);
      #1;
      build_model(11'h555, 4'd1, 64'h00000000000000A5);
      start_frame(11'h555, 4'd1, 64'h00000000000000A5);
      capture(200, -1, -1);
      stream_check("busy_start");
      bad = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (tx_busy !== 1'b0 || can_tx !== 1'b1) bad++;
      end
      check("busy_start_single_frame", bad, 0);
      $display("txn busy start: bits=%0d", cap_n);

      // Back-to-back: start in the tx_done cycle yields SOF on the next edge
      build_model(11'h2AA, 4'd2, 64'h0000000000003C0F);
      start_frame(11'h2AA, 4'd2, 64'h0000000000003C0F);
      capture(-1, -1, -1);
      stream_check("b2b_first");
      check("b2b_done_seen", (done_k > 0), 1);
      build_model(11'h0F0, 4'd3, 64'h0000000000FF00FF);
      start_frame(11'h0F0, 4'd3, 64'h0000000000FF00FF);
      check("b2b_sof_next_edge", can_tx, 0);
      check("b2b_busy_next_edge", tx_busy, 1);
      capture(-1, -1, -1);
      stream_check("b2b_second");
      $display("txn back-to-back: second bits=%0d", cap_n);

      // ACK slot driven dominant: no ack_err
      repeat (3) @(posedge clk);
      #1;
      build_model(11'h321, 4'd1, 64'h0000000000000055);
      start_frame(11'h321, 4'd1, 64'h0000000000000055);
      capture(-1, (exp_n - 12) * BC, (exp_n - 11) * BC);
      stream_check("ack_low");
      check("ack_low_ack_err", done_ack, 0);
      $display("txn ack driven low: ack_err=%0b", done_ack);

      // Abort mid-DATA through rst_n
      repeat (3) @(posedge clk);
      #1;
      start_frame(11'h123, 4'd8, 64'h0011223344556677);
      repeat (25 * BC) @(posedge clk);
      #1;
      check("abort_busy_before", tx_busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_can_tx", can_tx, 1);
      check("abort_busy", tx_busy, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (tx_done !== 1'b0 || tx_busy !== 1'b0 || can_tx !== 1'b1) bad++;
      end
      check("abort_no_done", bad, 0);
      $display("txn abort: idle violations=%0d", bad);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
